// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight destination tags and drives
// per-source bypass selects plus a load-use / interlock stall.
// Optional perf counters: define FWD_SCOREBOARD_PERF_EN.
module fwd_scoreboard #(
    parameter int REG_W      = 4,
    parameter int NUM_SRC    = 2,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_READY = 2,
    parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     forward_en,
    input  logic                     freeze,
    input  logic                     issue_valid,
    input  logic [REG_W-1:0]         issue_dst,
    input  logic                     issue_wb_en,
    input  logic                     issue_is_load,
    input  logic [NUM_SRC*REG_W-1:0] src,
    input  logic [NUM_SRC-1:0]       src_valid,
    output logic [NUM_SRC*SEL_W-1:0] sel_src,
`ifdef FWD_SCOREBOARD_PERF_EN
    output logic [31:0]              stall_cnt,
    output logic [31:0]              fwd_hit_cnt,
`endif
    output logic                     hazard_stall
);

    logic [FWD_DEPTH:1] r_v;
    logic [FWD_DEPTH:1] r_wb;
    logic [FWD_DEPTH:1] r_ld;
    logic [REG_W-1:0]   r_dst [1:FWD_DEPTH];

    logic [NUM_SRC*SEL_W-1:0] w_sel;
    logic                     w_stall;
    int                       w_hit;
    logic                     w_hit_ld;

    // Youngest matching stage per source, and the resulting stall
    always_comb begin
        w_sel    = '0;
        w_stall  = 1'b0;
        w_hit    = 0;
        w_hit_ld = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_hit    = 0;
            w_hit_ld = 1'b0;
            for (int k = FWD_DEPTH; k >= 1; k--) begin
                if (src_valid[i] && r_v[k] && r_wb[k] &&
                    r_dst[k] == src[i*REG_W +: REG_W]) begin
                    w_hit    = k;
                    w_hit_ld = r_ld[k];
                end
            end
            if (forward_en) begin
                w_sel[i*SEL_W +: SEL_W] = SEL_W'(w_hit);
                if (w_hit != 0 && w_hit_ld && w_hit < LOAD_READY)
                    w_stall = 1'b1;
            end else if (w_hit != 0) begin
                w_stall = 1'b1;
            end
        end
    end

    assign sel_src      = w_sel;
    assign hazard_stall = w_stall;

    // Shift the tag pipeline; a stalled issue enters as a bubble
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_v  <= '0;
            r_wb <= '0;
            r_ld <= '0;
            for (int k = 1; k <= FWD_DEPTH; k++)
                r_dst[k] <= '0;
        end else if (!freeze) begin
            for (int k = FWD_DEPTH; k >= 2; k--) begin
                r_v[k]   <= r_v[k-1];
                r_wb[k]  <= r_wb[k-1];
                r_ld[k]  <= r_ld[k-1];
                r_dst[k] <= r_dst[k-1];
            end
            r_v[1]   <= issue_valid & ~w_stall;
            r_wb[1]  <= issue_wb_en;
            r_ld[1]  <= issue_is_load;
            r_dst[1] <= issue_dst;
        end
    end

`ifdef FWD_SCOREBOARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_hit_cnt;
    logic [31:0] w_nz;

    // Count nonzero select fields this cycle
    always_comb begin
        w_nz = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (w_sel[i*SEL_W +: SEL_W] != '0)
                w_nz = w_nz + 32'd1;
    end

    // Stall and forward-hit counters, wrapping
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_hit_cnt   <= '0;
        end else if (!freeze) begin
            if (w_stall)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            else
                r_hit_cnt <= r_hit_cnt + w_nz;
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign fwd_hit_cnt = r_hit_cnt;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios with literal expectations
// plus randomized traffic against a queue-based reference model.
module tb_fwd_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       forward_en;
    logic       freeze;
    logic       issue_valid;
    logic [3:0] issue_dst;
    logic       issue_wb_en;
    logic       issue_is_load;
    logic [7:0] src;
    logic [1:0] src_valid;
    logic [3:0] sel_src;
    logic       hazard_stall;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit       v;
        bit [3:0] dst;
        bit       wb;
        bit       ld;
    } ent_t;

    // pipe[0] is the youngest producer (stage 1)
    ent_t pipe[$];

    fwd_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .forward_en   (forward_en),
        .freeze       (freeze),
        .issue_valid  (issue_valid),
        .issue_dst    (issue_dst),
        .issue_wb_en  (issue_wb_en),
        .issue_is_load(issue_is_load),
        .src          (src),
        .src_valid    (src_valid),
        .sel_src      (sel_src),
        .hazard_stall (hazard_stall)
    );

    always #5 clk = ~clk;

    function automatic void model_out(output logic [3:0] es,
                                      output logic est);
        es  = '0;
        est = 1'b0;
        for (int i = 0; i < 2; i++) begin
            int y;
            y = 0;
            for (int k = 1; k <= 2; k++)
                if (y == 0 && src_valid[i] && pipe[k-1].v &&
                    pipe[k-1].wb && pipe[k-1].dst == src[i*4 +: 4])
                    y = k;
            if (forward_en) begin
                es[i*2 +: 2] = y[1:0];
                if (y != 0 && pipe[y-1].ld && y < 2)
                    est = 1'b1;
            end else if (y != 0) begin
                est = 1'b1;
            end
        end
    endfunction

    task automatic model_reset();
        ent_t z;
        z = '{v: 1'b0, dst: 4'd0, wb: 1'b0, ld: 1'b0};
        pipe = '{z, z};
    endtask

    task automatic model_edge(input logic est);
        ent_t e;
        if (!rst) begin
            model_reset();
        end else if (!freeze) begin
            e.v   = issue_valid & ~est;
            e.dst = issue_dst;
            e.wb  = issue_wb_en;
            e.ld  = issue_is_load;
            pipe.push_front(e);
            void'(pipe.pop_back());
        end
    endtask

    task automatic at_neg();
        logic [3:0] es;
        logic       est;
        @(negedge clk);
        model_out(es, est);
        total++;
        if (sel_src !== es) begin
            bad++;
            $display("FAIL model_sel t=%0t got=%h exp=%h",
                     $time, sel_src, es);
        end
        total++;
        if (hazard_stall !== est) begin
            bad++;
            $display("FAIL model_stall t=%0t got=%b exp=%b",
                     $time, hazard_stall, est);
        end
    endtask

    task automatic adv();
        logic [3:0] es;
        logic       est;
        @(posedge clk);
        model_out(es, est);
        model_edge(est);
        #1;
    endtask

    task automatic lit(input string nm, input logic [3:0] xs,
                       input logic xst);
        total++;
        if (sel_src !== xs || hazard_stall !== xst) begin
            bad++;
            $display("FAIL %s got sel=%h stall=%b exp sel=%h stall=%b",
                     nm, sel_src, hazard_stall, xs, xst);
        end
    endtask

    task automatic iss(input logic v, input logic [3:0] d,
                       input logic wb, input logic ld);
        issue_valid   = v;
        issue_dst     = d;
        issue_wb_en   = wb;
        issue_is_load = ld;
    endtask

    task automatic srcs(input logic [3:0] s0, input logic v0,
                        input logic [3:0] s1, input logic v1);
        src       = {s1, s0};
        src_valid = {v1, v0};
    endtask

    task automatic idle(input int n);
        iss(0, 4'd0, 0, 0);
        srcs(4'd0, 0, 4'd0, 0);
        for (int i = 0; i < n; i++) begin
            at_neg();
            adv();
        end
    endtask

    initial begin
        rst = 1'b0;
        forward_en = 1'b1;
        freeze = 1'b0;
        iss(0, 4'd0, 0, 0);
        srcs(4'd0, 0, 4'd0, 0);
        @(posedge clk);
        model_reset();
        #1;
        rst = 1'b1;

        srcs(4'd3, 1, 4'd5, 1);
        at_neg();
        lit("reset_state", 4'h0, 1'b0);
        adv();

        // back-to-back ALU dependency
        iss(1, 4'd3, 1, 0);
        srcs(4'd0, 0, 4'd0, 0);
        at_neg(); adv();
        iss(0, 4'd0, 0, 0);
        srcs(4'd3, 1, 4'd0, 0);
        at_neg();
        lit("b2b_alu", 4'h1, 1'b0);
        adv();
        idle(2);

        // two-ago producer on source 1
        iss(1, 4'd5, 1, 0);
        at_neg(); adv();
        iss(1, 4'd6, 1, 0);
        at_neg(); adv();
        iss(0, 4'd0, 0, 0);
        srcs(4'd0, 0, 4'd5, 1);
        at_neg();
        lit("two_ago", 4'h8, 1'b0);
        adv();
        idle(2);

        // youngest producer wins
        iss(1, 4'd4, 1, 0);
        at_neg(); adv();
        at_neg(); adv();
        iss(0, 4'd0, 0, 0);
        srcs(4'd4, 1, 4'd0, 0);
        at_neg();
        lit("youngest", 4'h1, 1'b0);
        adv();
        idle(2);

        // load-use: one stall cycle then forward from stage 2
        iss(1, 4'd7, 1, 1);
        at_neg(); adv();
        iss(1, 4'd9, 1, 0);
        srcs(4'd7, 1, 4'd0, 0);
        at_neg();
        lit("load_use_stall", 4'h1, 1'b1);
        adv();
        at_neg();
        lit("load_use_retry", 4'h2, 1'b0);
        adv();
        idle(3);

        // interlock-only mode
        forward_en = 1'b0;
        iss(1, 4'd2, 1, 0);
        at_neg(); adv();
        iss(1, 4'd10, 1, 0);
        srcs(4'd2, 1, 4'd0, 0);
        at_neg();
        lit("ilk_stall1", 4'h0, 1'b1);
        adv();
        at_neg();
        lit("ilk_stall2", 4'h0, 1'b1);
        adv();
        iss(0, 4'd0, 0, 0);
        at_neg();
        lit("ilk_clear", 4'h0, 1'b0);
        adv();
        idle(2);
        iss(1, 4'd2, 1, 0);
        at_neg(); adv();
        iss(0, 4'd0, 0, 0);
        srcs(4'd2, 0, 4'd0, 0);
        at_neg();
        lit("ilk_srcinv", 4'h0, 1'b0);
        adv();
        forward_en = 1'b1;
        idle(3);

        // freeze holds a load at stage 1, then reset empties it
        iss(1, 4'd7, 1, 1);
        at_neg(); adv();
        freeze = 1'b1;
        iss(1, 4'd8, 1, 0);
        srcs(4'd7, 1, 4'd0, 0);
        for (int i = 0; i < 3; i++) begin
            at_neg();
            lit("freeze_hold", 4'h1, 1'b1);
            adv();
        end
        freeze = 1'b0;
        rst = 1'b0;
        at_neg();
        lit("pre_reset", 4'h1, 1'b1);
        adv();
        rst = 1'b1;
        srcs(4'd7, 1, 4'd8, 1);
        at_neg();
        lit("post_reset", 4'h0, 1'b0);
        adv();
        idle(2);

        // randomized traffic checked against the model
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 59) != 0);
            freeze     = ($urandom_range(0, 7) == 0);
            forward_en = ($urandom_range(0, 3) != 0);
            iss($urandom_range(0, 3) != 0,
                4'($urandom_range(0, 3)),
                $urandom_range(0, 4) != 0,
                $urandom_range(0, 2) == 0);
            srcs(4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                 4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
            at_neg();
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
